// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic initiator.
// Each accepted command becomes exactly one Wishbone cycle, and only one
// cycle is outstanding at a time. A cycle that gets no ack_i/err_i within
// TIMEOUT strobe cycles is abandoned. The response is held until the
// consumer takes it.
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // command side
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_sel,
    // response side
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic [15:0]     timeout_cnt,
    // Wishbone request
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    output logic [DW/8-1:0] sel_o,
    output logic            we_o,
    output logic            cyc_o,
    output logic            stb_o,
    // Wishbone response
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i
);

    // Wait counter must hold values 0..TIMEOUT-1; keep at least one bit when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;

    // Last permitted strobe cycle has been reached without a responder answer.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

    // Single FSM: every output is a register, so the bus sees no glitches and cmd_ready has no path from cmd_valid.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            timeout_cnt <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            we_o        <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        adr_o     <= cmd_addr;
                        dat_o     <= cmd_wdata;
                        sel_o     <= cmd_sel;
                        we_o      <= cmd_we;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        cmd_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= BUS;
                    end else begin
                        // Covers the first cycle after reset, when cmd_ready is still low.
                        cmd_ready <= 1'b1;
                    end
                end

                BUS: begin
                    if (ack_i || err_i || timeout_hit) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end

                    // ack_i takes priority over err_i, and err_i over the timeout.
                    if (ack_i) begin
                        rsp_rdata   <= we_o ? '0 : dat_i;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                    end else if (err_i) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master.
// u_dut uses TIMEOUT=16. u_dut4 uses TIMEOUT=4 and shares the same inputs;
// only the final priority test checks its outputs.
module tb_wb_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_ready;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, adr_o, dat_o;
    logic [15:0] timeout_cnt;
    logic [3:0]  sel_o;
    logic        we_o, cyc_o, stb_o;

    logic        cmd_ready4, rsp_valid4, rsp_err4, rsp_timeout4;
    logic [31:0] rsp_rdata4, adr_o4, dat_o4;
    logic [15:0] timeout_cnt4;
    logic [3:0]  sel_o4;
    logic        we_o4, cyc_o4, stb_o4;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk_i = ~clk_i;

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .timeout_cnt(timeout_cnt),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4),
        .rsp_err(rsp_err4), .rsp_timeout(rsp_timeout4), .timeout_cnt(timeout_cnt4),
        .adr_o(adr_o4), .dat_o(dat_o4), .sel_o(sel_o4), .we_o(we_o4),
        .cyc_o(cyc_o4), .stb_o(stb_o4),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a command and let it be accepted at the next edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel);
        int guard = 0;
        while (!cmd_ready && guard < 20) begin
            guard++;
            tick();
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Hold the responder quiet for 'waits' cycles, then answer; counts strobe-high cycles.
    task automatic bus_wait(input int waits, input logic do_ack, input logic do_err,
                            input logic [31:0] rd, output int stb_cycles);
        stb_cycles = 0;
        repeat (waits) begin
            if (stb_o) stb_cycles++;
            tick();
        end
        ack_i = do_ack;
        err_i = do_err;
        dat_i = rd;
        if (stb_o) stb_cycles++;
        tick();
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = 32'h0;
    endtask

    // Count strobe-high cycles with a silent responder, bounded.
    task automatic wait_stb_low(output int cycles);
        cycles = 0;
        while (stb_o && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_sel = '0; rsp_ready = 1'b0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;

        // Reset state
        tick();
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        rst_i = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write, ack one cycle after strobe
        issue(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF);
        check("wr_cyc", 32'(cyc_o), 32'd1);
        check("wr_stb", 32'(stb_o), 32'd1);
        check("wr_we", 32'(we_o), 32'd1);
        check("wr_adr", adr_o, 32'h08);
        check("wr_dat", dat_o, 32'hDEAD_BEEF);
        check("wr_sel", 32'(sel_o), 32'hF);
        check("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
        bus_wait(1, 1'b1, 1'b0, 32'hFFFF_FFFF, n);
        check("wr_stb_cycles", 32'(n), 32'd2);
        check("wr_cyc_drop", 32'(cyc_o), 32'd0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_dat_hold", dat_o, 32'hDEAD_BEEF);
        take_rsp("wr");

        // Read with 3 wait cycles, then backpressure with a queued command
        issue(1'b0, 32'h04, 32'h0, 4'hF);
        check("rd_we", 32'(we_o), 32'd0);
        check("rd_rsp_valid_early", 32'(rsp_valid), 32'd0);
        bus_wait(3, 1'b1, 1'b0, 32'h1234_5678, n);
        check("rd_stb_cycles", 32'(n), 32'd4);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h10; cmd_sel = 4'h3;
        repeat (5) begin
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_stb", 32'(stb_o), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp_hs_not_accepted", 32'(stb_o), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_queued_accepted", 32'(stb_o), 32'd1);
        check("bp_queued_adr", adr_o, 32'h10);
        check("bp_queued_sel", 32'(sel_o), 32'h3);
        bus_wait(0, 1'b1, 1'b0, 32'h0BAD_F00D, n);
        check("bp_queued_stb_cycles", 32'(n), 32'd1);
        check("bp_queued_rdata", rsp_rdata, 32'h0BAD_F00D);
        take_rsp("bp");

        // Timeout twice, TIMEOUT=16
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        wait_stb_low(n);
        check("to1_stb_cycles", 32'(n), 32'd16);
        check("to1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to1_rsp_err", 32'(rsp_err), 32'd1);
        check("to1_rsp_timeout", 32'(rsp_timeout), 32'd1);
        check("to1_rsp_rdata", rsp_rdata, 32'h0);
        check("to1_cnt", 32'(timeout_cnt), 32'd1);
        take_rsp("to1");
        issue(1'b1, 32'h24, 32'h5555_AAAA, 4'hF);
        wait_stb_low(n);
        check("to2_stb_cycles", 32'(n), 32'd16);
        check("to2_cnt", 32'(timeout_cnt), 32'd2);
        take_rsp("to2");

        // Error response (err_i alone)
        issue(1'b0, 32'h28, 32'h0, 4'hF);
        bus_wait(1, 1'b0, 1'b1, 32'hCAFE_CAFE, n);
        check("err_rsp_err", 32'(rsp_err), 32'd1);
        check("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("err_rsp_rdata", rsp_rdata, 32'h0);
        check("err_cnt_same", 32'(timeout_cnt), 32'd2);
        take_rsp("err");

        // Reset in the middle of a bus wait
        issue(1'b1, 32'h30, 32'h1111_2222, 4'hF);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        check("mid_rst_cyc", 32'(cyc_o), 32'd0);
        check("mid_rst_stb", 32'(stb_o), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cnt", 32'(timeout_cnt), 32'd0);
        rst_i = 1'b0;
        tick();
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);

        // ack_i and err_i together on the timeout threshold of the TIMEOUT=4 instance
        check("prio_ready4", 32'(cmd_ready4), 32'd1);
        issue(1'b0, 32'h40, 32'h0, 4'hF);
        check("prio_stb4", 32'(stb_o4), 32'd1);
        bus_wait(3, 1'b1, 1'b1, 32'hA5A5_5A5A, n);
        check("prio_rsp_valid4", 32'(rsp_valid4), 32'd1);
        check("prio_rsp_err4", 32'(rsp_err4), 32'd0);
        check("prio_rsp_timeout4", 32'(rsp_timeout4), 32'd0);
        check("prio_cnt4", 32'(timeout_cnt4), 32'd0);
        check("prio_rdata4", rsp_rdata4, 32'hA5A5_5A5A);
        check("prio_rsp_err", 32'(rsp_err), 32'd0);
        take_rsp("prio");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
